seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Execution-stage ALU, directly downstream of the ALU control decoder; consumes its 4-bit ALUOperation code.
- Operands A (rs) and B (rt/immediate) come from the datapath.
- Logic and add/sub ops finish in one cycle. SLL/SRL are computed iteratively, one bit position per cycle.
- start/busy/done handshake lets the multicycle controller stall on shifts.

Parameters:
- DATA_WIDTH, 32, operand/result width
- SHAMT_WIDTH, 5, shift-amount width; must satisfy 2**SHAMT_WIDTH >= DATA_WIDTH

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- ALUOperation  input  4  op code: 0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 SUB, 0101 SLL, 0110 SRL; all other codes invalid
- A  input  DATA_WIDTH  operand A
- B  input  DATA_WIDTH  operand B; the shifted operand for SLL/SRL
- shamt  input  SHAMT_WIDTH  shift amount
- busy  output  1  high while a shift iterates
- done  output  1  one-cycle pulse; result valid
- ALUResult  output  DATA_WIDTH  registered result; held until next done
- Zero  output  1  ALUResult == 0; registered with done
- invalid_op  output  1  registered with done; set for an unsupported code

Behaviour:
- Reset: sampled on clk rising edge when reset==0. All outputs 0; FSM to IDLE; internal counters/operands cleared. Reset mid-shift aborts the operation with no done.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start==1, sampled at edge N:
  - A, B, op and shamt are latched.
  - Non-shift op or invalid code: result computed and registered; go to DONE. done=1 during cycle N+1.
  - SLL/SRL with shamt==0: result=B; DONE at N+1.
  - SLL/SRL with shamt>0: go to SHIFT with count=shamt; busy=1 from cycle N+1.
- SHIFT: each cycle the working register shifts by 1 (left for SLL, right logical for SRL, zero fill) and count decrements.
  - When count reaches 0, go to DONE.
  - done=1 in cycle N+shamt+1; busy=0 in that cycle.
- DONE: lasts one cycle; done=1; then IDLE. A new start is accepted in the DONE cycle's successor only, giving a minimum issue interval of 2 cycles.
- start while busy or in DONE is ignored; latched operands are unaffected by input changes after sampling.
- Arithmetic: ADD/SUB are modulo 2**DATA_WIDTH (carry discarded). SUB = A - B. NOR = ~(A|B).
- Invalid code (including 0111, 1000–1111): ALUResult=0, Zero=1, invalid_op=1, 1-cycle latency.
- ALUResult, Zero and invalid_op update only on the cycle done rises; otherwise they are held.

Optional Feature:
- Macro SEQ_ALU_OVERFLOW_EN.
- Defined: adds output port Overflow (1 bit), registered with done. It is set on signed overflow:
  - ADD: A, B same sign and result sign differs.
  - SUB: A, B differ in sign and result sign differs from A.
  - Overflow is 0 for all other ops. Reset value 0. Result is still written (no trap).
- Undefined: no Overflow port; ADD/SUB wrap silently.

Decomposition:
- Shared package:
  - op-code constants matching the ALU control encoding (AND..SRL plus invalid default 1001)
  - FSM state typedef (IDLE/SHIFT/DONE)
  - DATA_WIDTH default
- One natural sub-module: seq_alu_shifter.
  - Holds the working register and down-counter.
  - Interface: load, dir, value, amount, busy, finished.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-SLL with shamt=20 -> all outputs 0, no done pulse; after release, FSM is IDLE and accepts start.
- ADD then SUB:
  - A=0x7FFFFFFF, B=1, op 0011 -> done at N+1, ALUResult=0x80000000, Zero=0 (Overflow=1 with macro).
  - A=5, B=5, op 0100 -> ALUResult=0, Zero=1.
- Logic: A=0xF0F0F0F0, B=0x0FF00FF0 -> AND gives 0x00F000F0, OR gives 0xFFF0FFF0, NOR gives 0x000F000F; each with 1-cycle latency.
- Shifts:
  - SLL with B=0x00000001, shamt=31 -> busy 31 cycles, done at N+32, result 0x80000000.
  - SRL with B=0x80000000, shamt=4 -> result 0x08000000 at N+5.
  - shamt=0 -> result=B at N+1.
- Handshake: pulse start again during busy with different operands -> ignored; the original result is delivered; back-to-back ADDs complete every 2 cycles.
- Invalid code 1001 and 0111 -> done at N+1, ALUResult=0, Zero=1, invalid_op=1; the next valid op clears invalid_op.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential execution-stage ALU: op-code encoding,
// FSM state type and default widths.
package seq_alu_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int SHAMT_WIDTH_DEF = 5;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_NOR     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_SLL     = 4'b0101;
  localparam logic [3:0] OP_SRL     = 4'b0110;
  localparam logic [3:0] OP_INVALID = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the multicycle controller and seq_alu.
// Optional Overflow signal exists only when SEQ_ALU_OVERFLOW_EN is defined.
interface seq_alu_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
);
  // Handshake: start is sampled only while the ALU is idle (not busy, not done).
  // done is a one-cycle pulse; ALUResult/Zero/invalid_op change only with done
  // and hold until the next done. busy is high exactly while a shift iterates.
  logic                   start;
  logic [3:0]             ALUOperation;
  logic [DATA_WIDTH-1:0]  A;
  logic [DATA_WIDTH-1:0]  B;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  ALUResult;
  logic                   Zero;
  logic                   invalid_op;
`ifdef SEQ_ALU_OVERFLOW_EN
  logic                   Overflow;
`endif

  modport master (
    output start, ALUOperation, A, B, shamt,
`ifdef SEQ_ALU_OVERFLOW_EN
    input  Overflow,
`endif
    input  busy, done, ALUResult, Zero, invalid_op
  );

  modport slave (
    input  start, ALUOperation, A, B, shamt,
`ifdef SEQ_ALU_OVERFLOW_EN
    output Overflow,
`endif
    output busy, done, ALUResult, Zero, invalid_op
  );

endinterface

// File: rtl/seq_alu_shifter.sv
// Iterative logical shifter: one bit position per cycle, zero fill.
// dir=0 shifts left (SLL), dir=1 shifts right (SRL).
module seq_alu_shifter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   dir,
  input  logic [DATA_WIDTH-1:0]  value,
  input  logic [SHAMT_WIDTH-1:0] amount,
  output logic                   busy,
  output logic                   finished,
  output logic [DATA_WIDTH-1:0]  result
);

  logic [DATA_WIDTH-1:0]  work;
  logic [SHAMT_WIDTH-1:0] count;
  logic                   dir_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      work  <= '0;
      count <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      work  <= value;
      count <= amount;
      dir_q <= dir;
    end else if (count != '0) begin
      work  <= result;
      count <= count - 1'b1;
    end
  end

  // result is the value after the shift happening this cycle, so the final
  // iteration can be captured directly by the result register.
  assign result   = dir_q ? (work >> 1) : (work << 1);
  assign busy     = (count != '0);
  assign finished = (count == SHAMT_WIDTH'(1));

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: logic/add/sub complete in one cycle, SLL/SRL iterate one bit
// per cycle. Optional Overflow output enabled by SEQ_ALU_OVERFLOW_EN.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  seq_alu_if.slave   bus,
  output state_t     dbg_state
);

  state_t state, state_nxt;

  logic                  accept;
  logic                  go_shift;
  logic                  res_load;
  logic                  op_invalid;
  logic [DATA_WIDTH-1:0] comb_res;
  logic [DATA_WIDTH-1:0] res_nxt;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;
  logic                  sh_busy;
  logic                  sh_finished;
  logic [DATA_WIDTH-1:0] sh_result;

  assign accept   = (state == ST_IDLE) && bus.start;
  assign go_shift = accept && is_shift_op(bus.ALUOperation) && (bus.shamt != '0);
  assign sum      = bus.A + bus.B;
  assign diff     = bus.A - bus.B;

  always_comb begin
    comb_res   = '0;
    op_invalid = 1'b0;
    case (bus.ALUOperation)
      OP_AND:  comb_res = bus.A & bus.B;
      OP_OR:   comb_res = bus.A | bus.B;
      OP_NOR:  comb_res = ~(bus.A | bus.B);
      OP_ADD:  comb_res = sum;
      OP_SUB:  comb_res = diff;
      OP_SLL,
      OP_SRL:  comb_res = bus.B;  // only reached with shamt == 0
      default: op_invalid = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = go_shift ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (sh_finished) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  seq_alu_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (go_shift),
    .dir      (bus.ALUOperation == OP_SRL),
    .value    (bus.B),
    .amount   (bus.shamt),
    .busy     (sh_busy),
    .finished (sh_finished),
    .result   (sh_result)
  );

  assign res_load = (accept && !go_shift) || sh_finished;
  assign res_nxt  = sh_finished ? sh_result : comb_res;

`ifdef SEQ_ALU_OVERFLOW_EN
  logic ovf_nxt;
  always_comb begin
    ovf_nxt = 1'b0;
    if (bus.ALUOperation == OP_ADD)
      ovf_nxt = (bus.A[DATA_WIDTH-1] == bus.B[DATA_WIDTH-1]) &&
                (sum[DATA_WIDTH-1] != bus.A[DATA_WIDTH-1]);
    else if (bus.ALUOperation == OP_SUB)
      ovf_nxt = (bus.A[DATA_WIDTH-1] != bus.B[DATA_WIDTH-1]) &&
                (diff[DATA_WIDTH-1] != bus.A[DATA_WIDTH-1]);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.ALUResult  <= '0;
      bus.Zero       <= 1'b0;
      bus.invalid_op <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
      bus.Overflow   <= 1'b0;
`endif
    end else if (res_load) begin
      bus.ALUResult  <= res_nxt;
      bus.Zero       <= (res_nxt == '0);
      bus.invalid_op <= !sh_finished && op_invalid;
`ifdef SEQ_ALU_OVERFLOW_EN
      bus.Overflow   <= !sh_finished && ovf_nxt;
`endif
    end
  end

  assign bus.busy  = sh_busy;
  assign bus.done  = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu: reset, one-cycle ops, iterative
// shifts, handshake corner cases and invalid op codes.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     compared;
  int     mismatched;
  int     lat;
  logic   busy_first;
  int     done_seen;

  seq_alu_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus ();

  seq_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge, then wait (bounded) for done.
  // On return we sit in the done cycle; lat counts cycles from the sampling edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output int lat_o, output logic busy_o);
    @(negedge clk);
    bus.start = 1'b1; bus.ALUOperation = op; bus.A = a; bus.B = b; bus.shamt = sh;
    @(negedge clk);
    bus.start = 1'b0;
    lat_o  = 1;
    busy_o = bus.busy;
    while (bus.done !== 1'b1 && lat_o < 64) begin
      @(negedge clk);
      lat_o++;
    end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.ALUOperation = OP_AND; bus.A = '0; bus.B = '0; bus.shamt = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", bus.ALUResult, 32'd0);
    check("rst_zero", 32'(bus.Zero), 32'd0);
    check("rst_invalid", 32'(bus.invalid_op), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b1;

    // driver: ADD with signed overflow, then SUB back to back
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, lat, busy_first);
    check("add_lat", lat, 1);
    check("add_res", bus.ALUResult, 32'h8000_0000);
    check("add_zero", 32'(bus.Zero), 32'd0);
    check("add_inv", 32'(bus.invalid_op), 32'd0);
`ifdef SEQ_ALU_OVERFLOW_EN
    check("add_ovf", 32'(bus.Overflow), 32'd1);
`endif
    run_op(OP_SUB, 32'd5, 32'd5, 5'd0, lat, busy_first);
    check("sub_lat", lat, 1);
    check("sub_res", bus.ALUResult, 32'd0);
    check("sub_zero", 32'(bus.Zero), 32'd1);
`ifdef SEQ_ALU_OVERFLOW_EN
    check("sub_ovf", 32'(bus.Overflow), 32'd0);
`endif

    // start presented during the DONE cycle is ignored
    run_op(OP_ADD, 32'd1, 32'd1, 5'd0, lat, busy_first);
    check("add2_res", bus.ALUResult, 32'd2);
    bus.start = 1'b1; bus.ALUOperation = OP_ADD; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_start_ign_done", 32'(bus.done), 32'd0);
    check("done_start_ign_state", 32'(dbg_state), 32'(ST_IDLE));
    check("done_start_ign_res", bus.ALUResult, 32'd2);

    // logic ops
    run_op(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, lat, busy_first);
    check("and_lat", lat, 1);
    check("and_res", bus.ALUResult, 32'h00F0_00F0);
    run_op(OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, lat, busy_first);
    check("or_lat", lat, 1);
    check("or_res", bus.ALUResult, 32'hFFF0_FFF0);
    run_op(OP_NOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, lat, busy_first);
    check("nor_lat", lat, 1);
    check("nor_res", bus.ALUResult, 32'h000F_000F);
    check("nor_zero", 32'(bus.Zero), 32'd0);
    @(negedge clk);
    check("done_pulse_width", 32'(bus.done), 32'd0);
    check("result_held", bus.ALUResult, 32'h000F_000F);

    // SLL by 31
    run_op(OP_SLL, 32'h0, 32'h0000_0001, 5'd31, lat, busy_first);
    check("sll31_busy_first", 32'(busy_first), 32'd1);
    check("sll31_lat", lat, 32);
    check("sll31_res", bus.ALUResult, 32'h8000_0000);
    check("sll31_busy_at_done", 32'(bus.busy), 32'd0);

    // SRL by 4 with a competing start while busy
    @(negedge clk);
    bus.start = 1'b1; bus.ALUOperation = OP_SRL; bus.A = '0; bus.B = 32'h8000_0000; bus.shamt = 5'd4;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    check("srl4_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b1; bus.ALUOperation = OP_ADD; bus.A = 32'd1; bus.B = 32'd2; bus.shamt = 5'd0;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("srl4_lat", lat, 5);
    check("srl4_res", bus.ALUResult, 32'h0800_0000);

    // shamt == 0 passes B through in one cycle
    run_op(OP_SLL, 32'h0, 32'h0000_1234, 5'd0, lat, busy_first);
    check("sh0_lat", lat, 1);
    check("sh0_busy", 32'(busy_first), 32'd0);
    check("sh0_res", bus.ALUResult, 32'h0000_1234);

    // invalid codes, then a valid op clears invalid_op
    run_op(OP_INVALID, 32'h1111_1111, 32'h2222_2222, 5'd3, lat, busy_first);
    check("inv9_lat", lat, 1);
    check("inv9_res", bus.ALUResult, 32'd0);
    check("inv9_zero", 32'(bus.Zero), 32'd1);
    check("inv9_flag", 32'(bus.invalid_op), 32'd1);
    run_op(4'b0111, 32'hDEAD_BEEF, 32'h1, 5'd7, lat, busy_first);
    check("inv7_lat", lat, 1);
    check("inv7_res", bus.ALUResult, 32'd0);
    check("inv7_flag", 32'(bus.invalid_op), 32'd1);
    run_op(OP_AND, 32'hFFFF_FFFF, 32'h0000_00FF, 5'd0, lat, busy_first);
    check("post_inv_flag", 32'(bus.invalid_op), 32'd0);
    check("post_inv_res", bus.ALUResult, 32'h0000_00FF);

    // reset mid-shift aborts with no done
    @(negedge clk);
    bus.start = 1'b1; bus.ALUOperation = OP_SLL; bus.A = '0; bus.B = 32'h3; bus.shamt = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_res", bus.ALUResult, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    done_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    run_op(OP_ADD, 32'd2, 32'd3, 5'd0, lat, busy_first);
    check("postrst_lat", lat, 1);
    check("postrst_res", bus.ALUResult, 32'd5);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
